// File: rtl/subr4u_pkg.sv
// Shared constants for the bit-serial unsigned subtractor: FSM state codes,
// default operand width and counter-width helper.
package subr4u_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_SHIFT = 2'd1;
  localparam state_t S_CHECK = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  // Bit-counter width for a WIDTH-bit serial pass; never narrower than 1 bit.
  function automatic int unsigned cnt_w(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/subr4u_fs_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bw_in, with borrow out.
module subr4u_fs_cell
  import subr4u_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic bw_i,
  output logic d_o,
  output logic bw_o
);

  assign d_o  = a_i ^ b_i ^ bw_i;
  assign bw_o = (~a_i & b_i) | (~(a_i ^ b_i) & bw_i);

endmodule

// File: rtl/subr4u_serial.sv
// Bit-serial unsigned subtractor D = A - B with valid/ready on both sides.
// Define SUBR4U_CHECK_EN to add a one-cycle re-add self-check driving fault.
module subr4u_serial
  import subr4u_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             fault
);

  localparam int unsigned        CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bw_q, bw_d;

  logic accept;
  logic shift_en;
  logic last_bit;
  logic d_bit;
  logic bw_bit;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (last_bit) begin
`ifdef SUBR4U_CHECK_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef SUBR4U_CHECK_EN
      S_CHECK: state_d = S_DONE;
`endif
      S_DONE: begin
        if (out_ready) state_d = in_valid ? S_SHIFT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and control decode
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    shift_en  = 1'b0;
    case (state_q)
      S_IDLE:  in_ready = 1'b1;
      S_SHIFT: shift_en = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  assign accept   = in_valid & in_ready;
  assign last_bit = (cnt_q == CNT_LAST);

  subr4u_fs_cell u_fs (
    .a_i  (a_q[0]),
    .b_i  (b_q[0]),
    .bw_i (bw_q),
    .d_o  (d_bit),
    .bw_o (bw_bit)
  );

  // Operands rotate rather than shift so they are intact again after WIDTH steps
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    diff_d = diff_q;
    bw_d   = bw_q;
    cnt_d  = cnt_q;
    if (accept) begin
      a_d   = a;
      b_d   = b;
      bw_d  = 1'b0;
      cnt_d = '0;
    end else if (shift_en) begin
      a_d    = {a_q[0], a_q[WIDTH-1:1]};
      b_d    = {b_q[0], b_q[WIDTH-1:1]};
      diff_d = {d_bit, diff_q[WIDTH-1:1]};
      bw_d   = bw_bit;
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      bw_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      diff_q <= diff_d;
      bw_q   <= bw_d;
      cnt_q  <= cnt_d;
    end
  end

  assign diff   = diff_q;
  assign borrow = bw_q;

`ifdef SUBR4U_CHECK_EN
  logic             fault_q, fault_d;
  logic [WIDTH:0]   readd_c;

  // diff + b must reproduce {borrow, a}
  assign readd_c = (WIDTH+1)'(diff_q) + (WIDTH+1)'(b_q);

  always_comb begin
    fault_d = fault_q;
    if (accept)                  fault_d = 1'b0;
    else if (state_q == S_CHECK) fault_d = (readd_c != {bw_q, a_q});
  end

  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule
